// File: rtl/alu_pkg.sv
// Shared funct codes, FSM encoding and the single-cycle ALU evaluator.
package alu_pkg;

  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } alu_res_t;

  // Single-cycle ops; MULTU never reaches here (it takes the MUL path),
  // so it falls into the unsupported branch like any unknown code.
  function automatic alu_res_t alu_eval(input logic [5:0]  f,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] hi,
                                        input logic [31:0] lo);
    alu_res_t r;
    r = '0;
    case (f)
      F_ADD:   r.data = a + b;
      F_SUB:   r.data = a - b;
      F_AND:   r.data = a & b;
      F_OR:    r.data = a | b;
      F_SLT:   r.data = {31'd0, ($signed(a) < $signed(b))};
      F_SRL:   r.data = a >> b[4:0];
      F_MFHI:  r.data = hi;
      F_MFLO:  r.data = lo;
      default: r.err  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_scheduler_mulu_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
module mulu_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  logic        run_q, run_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [32:0] step_sum;
  logic [63:0] step;

  // One shift-add step: the low half holds the remaining multiplier bits,
  // the high half accumulates; the whole thing shifts right each cycle.
  always_comb begin
    step_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    step     = {step_sum, prod_q[31:1]};
  end

  // done flags the 32nd step; product is that step's result so the owner
  // can latch it on the same edge the multiplier finishes.
  always_comb begin
    done    = run_q && (cnt_q == 5'd31);
    product = step;
  end

  // Next-state for the iteration registers.
  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start) begin
      run_d   = 1'b1;
      cnt_d   = 5'd0;
      mcand_d = a;
      prod_d  = {32'd0, b};
    end else if (run_q) begin
      prod_d = step;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) run_d = 1'b0;
    end
  end

  // Iteration state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q   <= 1'b0;
      cnt_q   <= 5'd0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Serialising ALU op scheduler: one op in flight, EXEC for single-cycle
// ops, MUL for the 32-cycle MULTU, RESP holds the result until taken.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  state_t      state_q, state_d;
  logic [5:0]  funct_q, funct_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;

  logic        accept;
  logic        mul_start;
  logic        mul_done;
  logic [63:0] mul_prod;
  alu_res_t    alu_res;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign mul_start = accept && (req_funct == F_MULTU);

  mulu_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign alu_res = alu_eval(funct_q, a_q, b_q, hi_q, lo_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: RESP returns to IDLE only, so a request waiting during
  // the response handshake is taken one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (req_funct == F_MULTU) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_MUL:  if (mul_done) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; response fields are forced to zero outside RESP.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_data  = (state_q == S_RESP) ? res_data_q : '0;
    rsp_err   = (state_q == S_RESP) && res_err_q;
  end

  // Datapath next-state: operand capture, result latch, HI/LO on MULTU done.
  always_comb begin
    funct_d    = funct_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    if (accept) begin
      funct_d = req_funct;
      a_d     = req_a;
      b_d     = req_b;
    end
    case (state_q)
      S_EXEC: begin
        res_data_d = alu_res.data;
        res_err_d  = alu_res.err;
      end
      S_MUL: if (mul_done) begin
        hi_d       = mul_prod[63:32];
        lo_d       = mul_prod[31:0];
        res_data_d = mul_prod[31:0];
        res_err_d  = 1'b0;
      end
      S_RESP: if (rsp_ready) begin
        res_data_d = '0;
        res_err_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      funct_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      funct_q    <= funct_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench: vector table, corner sequences, then random ops against a model.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  alu_op_scheduler #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct (req_funct),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        e;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the funct rules, HI/LO kept as a 64-bit product.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic e, output int lat);
    logic [63:0] p;
    d = 0; e = 0; lat = 2;
    case (f)
      6'd32: d = a + b;
      6'd34: d = a - b;
      6'd36: d = a & b;
      6'd37: d = a | b;
      6'd42: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:  d = a >> b[4:0];
      6'd25: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; d = m_lo; lat = 33;
      end
      6'd16: d = m_hi;
      6'd18: d = m_lo;
      default: e = 1;
    endcase
  endtask

  // Issue one op with rsp_ready=1. lat = index of the posedge (accept edge = 0)
  // at which the response handshake happens.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic e, output int lat, output bit to);
    int n;
    to = 0; n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin to = 1; return; end
    req_valid = 1; req_funct = f; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin to = 1; return; end
    d = rsp_data; e = rsp_err;
    @(posedge clk);
  endtask

  task automatic run_chk(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic ee, input int el);
    logic [31:0] d; logic e; int lat; bit to;
    do_op(f, a, b, d, e, lat, to);
    if (to) begin
      checks++; errors++;
      $display("FAIL %s timeout: no handshake within bound", tag);
      return;
    end
    chk({tag, " data"}, d, ed);
    chk({tag, " err"}, {31'd0, e}, {31'd0, ee});
    chk({tag, " lat"}, 32'(lat), 32'(el));
  endtask

  vec_t vt[14];

  initial begin
    logic [31:0] md; logic me; int ml;
    logic [5:0] fl[10];
    int n;
    bit seen;

    reset = 0; req_valid = 0; req_funct = 0; req_a = 0; req_b = 0; rsp_ready = 1;
    m_hi = 0; m_lo = 0;

    vt[0]  = '{6'd32, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 2};
    vt[1]  = '{6'd42, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 2};
    vt[2]  = '{6'd2,  32'h80000000, 32'h0000003F, 32'h00000001, 1'b0, 2};
    vt[3]  = '{6'd34, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 2};
    vt[4]  = '{6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2};
    vt[5]  = '{6'd37, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 2};
    vt[6]  = '{6'd42, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2};
    vt[7]  = '{6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33};
    vt[8]  = '{6'd16, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 1'b0, 2};
    vt[9]  = '{6'd18, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 2};
    vt[10] = '{6'd63, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 2};
    vt[11] = '{6'd16, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 1'b0, 2};
    vt[12] = '{6'd25, 32'h00000005, 32'h00000007, 32'h00000023, 1'b0, 33};
    vt[13] = '{6'd16, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset = 1;
    @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      model(vt[i].f, vt[i].a, vt[i].b, md, me, ml);
      run_chk($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].d, vt[i].e, vt[i].lat);
    end

    // Backpressure: ADD 3+4 held in RESP, a second request must wait
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 1; req_funct = 6'd32; req_a = 3; req_b = 4;
    @(posedge clk);
    @(negedge clk);
    req_funct = 6'd34; req_a = 9; req_b = 1;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp hold data", rsp_data, 32'd7);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp post idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp post idle req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 0;
    chk("bp sub busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("bp sub valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp sub data", rsp_data, 32'd8);
    @(posedge clk);

    // Reset during MUL cycle 10
    @(negedge clk);
    req_valid = 1; req_funct = 6'd25; req_a = 5; req_b = 7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (9) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    m_hi = 0; m_lo = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("mul abort no rsp", {31'd0, seen}, 32'd0);
    run_chk("abort mflo", 6'd18, 0, 0, 32'd0, 1'b0, 2);
    run_chk("abort mfhi", 6'd16, 0, 0, 32'd0, 1'b0, 2);

    // Random ops vs model
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18, 6'd63};
    for (int i = 0; i < 40; i++) begin
      logic [5:0] f; logic [31:0] a, b;
      f = fl[$urandom_range(0, 9)];
      if (f == 6'd63 && $urandom_range(0, 1) == 1) f = 6'd0;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {32{a[0]}};
      model(f, a, b, md, me, ml);
      run_chk($sformatf("rnd%0d f%0d", i, f), f, a, b, md, me, ml);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  scheduler accepts an operation this cycle.
REQ-006 req_funct  input  6  funct code: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULTU=25, MFHI=16, MFLO=18.
REQ-007 req_a, req_b  input  32 each  operands; req_b[4:0] is the shift amount for SRL.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result.
REQ-010 rsp_data  output  32  result value.
REQ-011 rsp_err  output  1  unsupported funct flag, qualified by rsp_valid.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; handshake is req_valid&&req_ready; operands and funct are captured at that edge.
REQ-015 IDLE -> MUL on accepted MULTU; IDLE -> EXEC on any other accepted funct.
REQ-016 EXEC SHALL last exactly one cycle, compute the result, then go to RESP; rsp_valid rises 2 cycles after the accept edge.
REQ-017 ADD/SUB SHALL wrap modulo 2^32, no overflow flag; AND/OR bitwise; SLT signed compare giving 1 or 0; SRL logical, zero-fill, by req_b[4:0].
REQ-018 MFHI/MFLO SHALL return the HI/LO register; the FSM serialises all ops, so a MFHI/MFLO after MULTU always sees the completed product.
REQ-019 Unsupported funct SHALL produce rsp_err=1, rsp_data=0, and leave HI/LO unchanged.
REQ-020 MUL SHALL run the iterative multiplier for exactly 32 cycles (one bit/cycle), write the unsigned 64-bit product to {HI,LO}, then go to RESP with rsp_data=LO, rsp_err=0; rsp_valid rises 33 cycles after the accept edge.
REQ-021 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_valid&&rsp_ready; the next state is then IDLE, and no new request is accepted in that same cycle.
REQ-022 Outside RESP, rsp_valid SHALL be 0 and rsp_data/rsp_err SHALL be 0.
REQ-023 HI/LO SHALL change only on MULTU completion or reset.

Reset
REQ-024 With reset=0 at a rising edge: state=IDLE, HI=LO=0, multiplier counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0; req_ready=1 from the first cycle after reset releases.
REQ-025 Reset during MUL or RESP SHALL abort the operation with no response and no partial HI/LO update.

Structure
REQ-026 Funct code constants and the FSM state encoding SHALL live in a shared package (alu_pkg), reused by the ALU control logic.
REQ-027 The shift-add multiplier SHALL be one sub-module, mulu_iter (start, 32-cycle counter, done pulse, 64-bit product); the rest is FSM plus combinational ALU/shift logic in this module.

Verification
REQ-028 ADD a=0xFFFFFFFF b=0x00000001 -> rsp_data=0x00000000, rsp_valid at accept+2.
REQ-029 SLT a=0xFFFFFFFF b=0x00000001 -> 1; SRL a=0x80000000 b=0x0000003F -> 0x00000001.
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> rsp at accept+33 with data 0x00000001; following MFHI -> 0xFFFFFFFE and MFLO -> 0x00000001.
REQ-031 Backpressure: hold rsp_ready=0 for 5 cycles after ADD 3+4 -> rsp_data stays 7, req_ready stays 0, a second req_valid is not accepted until after release.
REQ-032 Reset asserted at MUL cycle 10 of MULTU 5x7 -> no rsp_valid; following MFLO -> 0.
REQ-033 funct=6'd63 -> rsp_err=1, rsp_data=0, HI/LO unchanged.
